// File: rtl/i2c_write_master_if.sv
// I2C write master bus bundle: the request inputs, the SCL/SDA lines and the status flags.
// The master modport is the RTL side, the slave modport is the side that requests writes and models the wire.
interface i2c_write_master_if;
  logic       go;
  logic [6:0] dev_addr;
  logic [7:0] reg_addr;
  logic [7:0] wr_data;
  logic       sda_i;
  logic       scl;
  logic       sda_o;
  logic       busy;
  logic       done;
  logic       nack;

  modport master (
    input  go, dev_addr, reg_addr, wr_data, sda_i,
    output scl, sda_o, busy, done, nack
  );

  modport slave (
    output go, dev_addr, reg_addr, wr_data, sda_i,
    input  scl, sda_o, busy, done, nack
  );
endinterface

// File: rtl/i2c_write_master.sv
// I2C write master: START, {addr,W}, register byte, data byte, STOP, with an ACK check after each byte.
// Everything advances in SCL quarter periods of CLK_DIV system clocks. SCL/SDA are registered and
// are computed from the position the FSM is about to enter, so they change only on the first clock of a quarter.
module i2c_write_master #(
  parameter int CLK_DIV = 4
) (
  input logic             clk,
  input logic             reset,
  i2c_write_master_if.master bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] BIT   = 3'd2;
  localparam logic [2:0] ACK   = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  localparam logic [7:0] TICK_MAX = 8'(CLK_DIV - 1);

  logic [2:0]  state, state_n;
  logic [7:0]  q_timer;
  logic [1:0]  qtr, qtr_n;
  logic [2:0]  bit_cnt, bit_n;
  logic [1:0]  byte_cnt, byte_n;
  logic [23:0] shift_bytes;
  logic        ack_sample;
  logic        tick;
  logic [7:0]  cur_byte;
  logic        cur_bit;
  logic        scl_n, sda_n;

  assign tick = (q_timer == TICK_MAX);

  // Select the bit that will be on SDA in the position the FSM is moving to.
  always_comb begin
    cur_byte = shift_bytes[7:0];
    case (byte_n)
      2'd0:    cur_byte = shift_bytes[23:16];
      2'd1:    cur_byte = shift_bytes[15:8];
      default: cur_byte = shift_bytes[7:0];
    endcase
    cur_bit = cur_byte[bit_n];
  end

  // Next position in the transaction: state, quarter within the phase, bit and byte counters.
  always_comb begin
    state_n = state;
    qtr_n   = qtr;
    bit_n   = bit_cnt;
    byte_n  = byte_cnt;
    case (state)
      IDLE: begin
        if (bus.go) begin
          state_n = START;
          qtr_n   = 2'd0;
          bit_n   = 3'd7;
          byte_n  = 2'd0;
        end
      end
      DONE: state_n = IDLE;
      default: begin
        if (tick) begin
          qtr_n = qtr + 2'd1;
          case (state)
            START: begin
              if (qtr == 2'd1) begin
                state_n = BIT;
                qtr_n   = 2'd0;
                bit_n   = 3'd7;
                byte_n  = 2'd0;
              end
            end
            BIT: begin
              if (qtr == 2'd3) begin
                qtr_n = 2'd0;
                if (bit_cnt == 3'd0) state_n = ACK;
                else                 bit_n   = bit_cnt - 3'd1;
              end
            end
            ACK: begin
              if (qtr == 2'd3) begin
                qtr_n = 2'd0;
                if (ack_sample || byte_cnt == 2'd2) begin
                  state_n = STOP;
                end else begin
                  state_n = BIT;
                  bit_n   = 3'd7;
                  byte_n  = byte_cnt + 2'd1;
                end
              end
            end
            STOP: begin
              if (qtr == 2'd3) begin
                state_n = DONE;
                qtr_n   = 2'd0;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  // Line levels for the next position; SCL is low in quarters 0-1 and high in 2-3 of every clocked slot.
  always_comb begin
    scl_n = 1'b1;
    sda_n = 1'b1;
    case (state_n)
      START: begin
        scl_n = 1'b1;
        sda_n = 1'b0;
      end
      BIT: begin
        scl_n = qtr_n[1];
        sda_n = cur_bit;
      end
      ACK: begin
        scl_n = qtr_n[1];
        sda_n = 1'b1;
      end
      STOP: begin
        scl_n = qtr_n[1];
        sda_n = (qtr_n == 2'd3);
      end
      default: ;
    endcase
  end

  // Register position, quarter timer, outputs, latched bytes and the ACK sample taken on the last clock of Q2.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      q_timer     <= 8'd0;
      qtr         <= 2'd0;
      bit_cnt     <= 3'd0;
      byte_cnt    <= 2'd0;
      shift_bytes <= 24'd0;
      ack_sample  <= 1'b0;
      bus.scl     <= 1'b1;
      bus.sda_o   <= 1'b1;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.nack    <= 1'b0;
    end else begin
      state    <= state_n;
      qtr      <= qtr_n;
      bit_cnt  <= bit_n;
      byte_cnt <= byte_n;
      if (state == IDLE || state == DONE || tick) q_timer <= 8'd0;
      else                                        q_timer <= q_timer + 8'd1;
      bus.scl   <= scl_n;
      bus.sda_o <= sda_n;
      bus.busy  <= (state_n != IDLE) && (state_n != DONE);
      bus.done  <= (state_n == DONE);
      if (state == IDLE && bus.go) begin
        shift_bytes <= {bus.dev_addr, 1'b0, bus.reg_addr, bus.wr_data};
        bus.nack    <= 1'b0;
      end
      if (state == ACK && qtr == 2'd2 && tick) begin
        ack_sample <= bus.sda_i;
        if (bus.sda_i) bus.nack <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2c_write_master.sv
// Bench for i2c_write_master: two instances (CLK_DIV=4 and CLK_DIV=1) share one clock and reset.
// A bus monitor decodes the wire (START/STOP, bits at SCL rising edges, SCL phase widths) and a slave
// model drives ACK/NACK; each transaction is compared against a byte-level model of the write.
module tb_i2c_write_master;

  logic clk = 1'b0;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;

  always #5 clk = ~clk;

  // Free-running cycle counter used to time latencies and SCL phases.
  always @(posedge clk) cyc <= cyc + 1;

  i2c_write_master_if bus4();
  i2c_write_master_if bus1();

  i2c_write_master #(.CLK_DIV(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
  i2c_write_master #(.CLK_DIV(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  logic       go_v[2];
  logic [6:0] dev_v[2];
  logic [7:0] reg_v[2];
  logic [7:0] dat_v[2];
  logic       slave_drive[2];

  assign bus4.go       = go_v[0];
  assign bus4.dev_addr = dev_v[0];
  assign bus4.reg_addr = reg_v[0];
  assign bus4.wr_data  = dat_v[0];
  assign bus4.sda_i    = bus4.sda_o & slave_drive[0];
  assign bus1.go       = go_v[1];
  assign bus1.dev_addr = dev_v[1];
  assign bus1.reg_addr = reg_v[1];
  assign bus1.wr_data  = dat_v[1];
  assign bus1.sda_i    = bus1.sda_o & slave_drive[1];

  logic scl_w[2], sda_w[2], sdao_w[2], busy_w[2], done_w[2], nack_w[2];
  assign scl_w[0]  = bus4.scl;   assign scl_w[1]  = bus1.scl;
  assign sda_w[0]  = bus4.sda_i; assign sda_w[1]  = bus1.sda_i;
  assign sdao_w[0] = bus4.sda_o; assign sdao_w[1] = bus1.sda_o;
  assign busy_w[0] = bus4.busy;  assign busy_w[1] = bus1.busy;
  assign done_w[0] = bus4.done;  assign done_w[1] = bus1.done;
  assign nack_w[0] = bus4.nack;  assign nack_w[1] = bus1.nack;

  // Monitor state (written only by monitorBus) and model state (written only by the stimulus tasks).
  int   rise_cnt[2], start_cnt[2], stop_cnt[2], phase_bad[2], done_cnt[2];
  int   rise_cyc[2], fall_cyc[2];
  bit   rise_ok[2], fall_ok[2];
  logic prev_scl[2], prev_sda[2];
  logic rise_bits[2][64];
  logic [2:0] resp[2];
  logic [7:0] exp_bytes[2][3];
  int   exp_n[2];
  logic exp_nack[2];
  int   go_cyc[2], start_base[2], stop_base[2], phase_base[2];

  function automatic int divOf(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Decode one bus at a falling clock edge and play the addressed slave (resp bit b = 1 means NACK byte b).
  task automatic monitorBus(input int k);
    int pos;
    int byte_idx;
    if (reset) begin
      slave_drive[k] = 1'b1;
      prev_scl[k]    = 1'b1;
      prev_sda[k]    = 1'b1;
      rise_ok[k]     = 1'b0;
      fall_ok[k]     = 1'b0;
    end else begin
      if (prev_scl[k] && scl_w[k] && sda_w[k] !== prev_sda[k]) begin
        if (!sda_w[k]) begin
          start_cnt[k]++;
          rise_cnt[k]    = 0;
          rise_ok[k]     = 1'b0;
          fall_ok[k]     = 1'b0;
          slave_drive[k] = 1'b1;
        end else begin
          stop_cnt[k]++;
        end
      end
      if (!prev_scl[k] && scl_w[k]) begin
        if (rise_cnt[k] < 64) rise_bits[k][rise_cnt[k]] = sda_w[k];
        rise_cnt[k]++;
        if (fall_ok[k] && (cyc - fall_cyc[k]) != 2 * divOf(k)) phase_bad[k]++;
        rise_cyc[k] = cyc;
        rise_ok[k]  = 1'b1;
      end
      if (prev_scl[k] && !scl_w[k]) begin
        if (rise_ok[k] && (cyc - rise_cyc[k]) != 2 * divOf(k)) phase_bad[k]++;
        fall_cyc[k] = cyc;
        fall_ok[k]  = 1'b1;
        slave_drive[k] = 1'b1;
        if (rise_cnt[k] > 0) begin
          pos      = (rise_cnt[k] - 1) % 9;
          byte_idx = (rise_cnt[k] - 1) / 9;
          if (pos == 7 && byte_idx < 3) slave_drive[k] = resp[k][byte_idx];
        end
      end
      if (done_w[k]) done_cnt[k]++;
      prev_scl[k] = scl_w[k];
      prev_sda[k] = sda_w[k];
    end
  endtask

  // Run the monitor for both instances away from the active clock edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) monitorBus(k);
  end

  // Byte-level model: bytes sent stop at the first NACK, and the transaction length follows from that.
  task automatic setModel(input int k, input logic [6:0] d, input logic [7:0] r, input logic [7:0] w,
                          input logic [2:0] rp);
    resp[k]         = rp;
    exp_bytes[k][0] = {d, 1'b0};
    exp_bytes[k][1] = r;
    exp_bytes[k][2] = w;
    exp_n[k]        = rp[0] ? 1 : (rp[1] ? 2 : 3);
    exp_nack[k]     = rp[exp_n[k] - 1];
    start_base[k]   = start_cnt[k];
    stop_base[k]    = stop_cnt[k];
    phase_base[k]   = phase_bad[k];
  endtask

  task automatic applyStimulus(input int k, input logic [6:0] d, input logic [7:0] r, input logic [7:0] w,
                               input logic [2:0] rp, input bit hold);
    dev_v[k] = d;
    reg_v[k] = r;
    dat_v[k] = w;
    setModel(k, d, r, w, rp);
    go_v[k] = 1'b1;
    @(negedge clk);
    go_cyc[k] = cyc;
    checkOutput($sformatf("start_busy_k%0d", k), busy_w[k], 1);
    checkOutput($sformatf("start_sda_k%0d", k), sdao_w[k], 0);
    if (!hold) go_v[k] = 1'b0;
  endtask

  task automatic awaitDone(input int k, input bit go_at_done);
    int waited = 0;
    int lat;
    logic [7:0] obs;
    while (done_w[k] !== 1'b1 && waited < 140 * divOf(k) + 40) begin
      @(negedge clk);
      waited++;
    end
    if (done_w[k] !== 1'b1) begin
      checkOutput($sformatf("done_timeout_k%0d", k), 0, 1);
    end else begin
      lat = cyc - go_cyc[k] + 1;
      checkOutput($sformatf("latency_k%0d", k), lat, (6 + 36 * exp_n[k]) * divOf(k) + 1);
      checkOutput($sformatf("done_busy_k%0d", k), busy_w[k], 0);
      checkOutput($sformatf("nack_k%0d", k), nack_w[k], exp_nack[k]);
      if (go_at_done) begin
        go_v[k]  = 1'b1;
        dev_v[k] = ~dev_v[k];
        reg_v[k] = ~reg_v[k];
      end
      @(negedge clk);
      if (go_at_done) go_v[k] = 1'b0;
      checkOutput($sformatf("done_pulse_k%0d", k), done_w[k], 0);
      for (int b = 0; b < exp_n[k]; b++) begin
        obs = 8'h00;
        for (int i = 0; i < 8; i++) obs = {obs[6:0], rise_bits[k][9 * b + i]};
        checkOutput($sformatf("byte%0d_k%0d", b, k), obs, exp_bytes[k][b]);
        checkOutput($sformatf("ackbit%0d_k%0d", b, k), rise_bits[k][9 * b + 8], resp[k][b]);
      end
      checkOutput($sformatf("stop_rise_sda_k%0d", k), rise_bits[k][9 * exp_n[k]], 0);
      checkOutput($sformatf("rise_count_k%0d", k), rise_cnt[k], 9 * exp_n[k] + 1);
      checkOutput($sformatf("start_cond_k%0d", k), start_cnt[k] - start_base[k], 1);
      checkOutput($sformatf("stop_cond_k%0d", k), stop_cnt[k] - stop_base[k], 1);
      checkOutput($sformatf("scl_phase_k%0d", k), phase_bad[k] - phase_base[k], 0);
    end
  endtask

  // Scenario sequence: reset, directed writes and NACKs, reset abort, ignored go, held go, random writes.
  initial begin
    int dbase;
    logic [2:0] rp;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      go_v[k] = 1'b0; dev_v[k] = 7'h00; reg_v[k] = 8'h00; dat_v[k] = 8'h00; resp[k] = 3'b000;
    end
    repeat (3) @(negedge clk);
    checkOutput("reset_scl", scl_w[0], 1);
    checkOutput("reset_sda", sdao_w[0], 1);
    checkOutput("reset_busy", busy_w[0], 0);
    checkOutput("reset_done", done_w[0], 0);
    checkOutput("reset_nack", nack_w[0], 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] full write, address NACK, data NACK at CLK_DIV=4");
    applyStimulus(0, 7'h50, 8'hA5, 8'h3C, 3'b000, 1'b0); awaitDone(0, 1'b0);
    applyStimulus(0, 7'h50, 8'hA5, 8'h3C, 3'b001, 1'b0); awaitDone(0, 1'b0);
    applyStimulus(0, 7'h50, 8'hA5, 8'h3C, 3'b100, 1'b0); awaitDone(0, 1'b0);

    $display("[TB] full write at CLK_DIV=1");
    applyStimulus(1, 7'h50, 8'hA5, 8'h3C, 3'b000, 1'b0); awaitDone(1, 1'b0);

    $display("[TB] reset during the register byte");
    applyStimulus(0, 7'h50, 8'hA5, 8'h3C, 3'b000, 1'b0);
    repeat (199) @(negedge clk);
    dbase = done_cnt[0];
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_scl", scl_w[0], 1);
    checkOutput("abort_sda", sdao_w[0], 1);
    checkOutput("abort_busy", busy_w[0], 0);
    checkOutput("abort_nack", nack_w[0], 0);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    checkOutput("abort_no_done", done_cnt[0] - dbase, 0);
    applyStimulus(0, 7'h50, 8'hA5, 8'h3C, 3'b000, 1'b0); awaitDone(0, 1'b0);

    $display("[TB] go while busy and in the done cycle");
    applyStimulus(0, 7'h2B, 8'h96, 8'h0F, 3'b000, 1'b0);
    repeat (100) @(negedge clk);
    go_v[0] = 1'b1; dev_v[0] = 7'h11; reg_v[0] = 8'h22; dat_v[0] = 8'h33;
    @(negedge clk);
    go_v[0] = 1'b0;
    awaitDone(0, 1'b1);
    repeat (4) @(negedge clk);
    checkOutput("ignored_go_busy", busy_w[0], 0);
    checkOutput("ignored_go_sda", sdao_w[0], 1);

    $display("[TB] go held high across done");
    applyStimulus(0, 7'h7F, 8'h01, 8'h80, 3'b000, 1'b1);
    awaitDone(0, 1'b0);
    checkOutput("idle_gap_busy", busy_w[0], 0);
    checkOutput("idle_gap_sda", sdao_w[0], 1);
    setModel(0, 7'h7F, 8'h01, 8'h80, 3'b000);
    @(negedge clk);
    go_cyc[0] = cyc;
    checkOutput("restart_busy", busy_w[0], 1);
    checkOutput("restart_sda", sdao_w[0], 0);
    go_v[0] = 1'b0;
    awaitDone(0, 1'b0);

    $display("[TB] random writes");
    for (int t = 0; t < 8; t++) begin
      int k;
      k  = (t % 3 == 2) ? 1 : 0;
      rp = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      applyStimulus(k, 7'($urandom), 8'($urandom), 8'($urandom), rp, 1'b0);
      awaitDone(k, 1'b0);
      repeat ($urandom_range(1, 5)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_write_master.md
# i2c_write_master

Synchronous I2C bus master that generates one complete 3-byte write transaction on SCL/SDA: START, device address + W, register byte, data byte, and STOP. It checks the slave ACK after each byte. It is the driving end of the bus whose traffic the raw I2C monitor FSM decodes, and it serves as the stimulus source and configuration writer in the same design. There is no clock stretching, no repeated start and no read support.

## Interface
Parameters:
- CLK_DIV, default 4: system clocks per SCL quarter-period. Legal range is 1..255. One SCL bit is 4*CLK_DIV clocks.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  reset reset, synchronous, active-high.
- go  input  1  transaction request; sampled only in IDLE.
- dev_addr  input  7  7-bit slave address; latched on accepted go.
- reg_addr  input  8  register byte; latched on accepted go.
- wr_data  input  8  data byte; latched on accepted go.
- sda_i  input  1  bus SDA level; used only for ACK sampling.
- scl  output  1  SCL level; 1 means released/high.
- sda_o  output  1  SDA drive; 0 pulls low, 1 releases.
- busy  output  1  high from the cycle after go is accepted until done.
- done  output  1  one-cycle pulse at the end of the transaction.
- nack  output  1  sticky; set when any ACK slot reads 1, cleared on the next accepted go.

## Operation
- Reset values: scl=1, sda_o=1, busy=0, done=0, nack=0, state=IDLE, quarter timer=0, bit counter=0, byte counter=0.
- IDLE: scl=1, sda_o=1.
  - go=1 latches the shift bytes {dev_addr,1'b0}, reg_addr, wr_data, clears nack, and moves to START.
  - go while busy is ignored.
- Quarter tick: the timer counts 0..CLK_DIV-1 and ticks on the terminal count. Each phase lasts a whole number of quarters. Outputs change only on the first clock of a quarter.
- START, 2 quarters: scl=1, sda_o=0. Then BIT with byte 0, bit 7.
- BIT, 4 quarters per bit, MSB first:
  - Q0 and Q1: scl=0, sda_o=current bit, set at Q0 entry.
  - Q2 and Q3: scl=1, sda held.
  - After 8 bits go to ACK.
- ACK, 4 quarters: sda_o=1 (released); Q0/Q1 scl=0, Q2/Q3 scl=1.
  - sda_i is sampled on the last clock of Q2.
  - Sample 1: set nack and go to STOP.
  - Sample 0 with bytes remaining: go to BIT on the next byte.
  - Sample 0 after byte 2: go to STOP.
- STOP, 4 quarters:
  - Q0/Q1: scl=0, sda_o=0.
  - Q2: scl=1, sda_o=0.
  - Q3: scl=1, sda_o=1.
- DONE, 1 clock: done=1, busy=0, scl=1, sda_o=1. Then IDLE.
- SDA never changes while scl=1, except the START falling edge and the STOP rising edge.
- Reset mid-transaction: on the next edge both lines are released (scl=1, sda_o=1) and state goes to IDLE. No STOP is generated, no done pulse, and nack is cleared.

## Timing
- An accepted go at edge N gives busy=1 and START outputs (sda_o=0) from N+1.
- Full ACKed transaction length is 2 + 27*4 + 4 = 114 quarters = 114*CLK_DIV clocks from START entry. done follows on the next clock.
  - CLK_DIV=4: done is asserted 457 clocks after the go edge.
- NACK on the address byte: 2 + 36 + 4 = 42 quarters, then done.
- A go asserted in the same cycle as done is ignored. go is accepted from the cycle after done.
- go held continuously produces back-to-back transactions with one IDLE clock between them.

## Test plan
- Full write: CLK_DIV=4, dev_addr=0x50, reg_addr=0xA5, wr_data=0x3C, sda_i=0 in every ACK slot.
  - SDA sampled at each SCL rising edge reads 0xA0, ack, 0xA5, ack, 0x3C, ack, then STOP.
  - done arrives at go+457, nack=0.
- Address NACK: same inputs, sda_i=1 during the first ACK slot.
  - STOP follows immediately, nack=1, no reg/data bits on the bus, done at go+169.
- Data NACK: sda_i=1 only in the third ACK slot.
  - Full waveform as in the first scenario, nack=1, done at go+457.
- Protocol checker over the whole run: no SDA change while SCL=1 except START and STOP.
  - SCL high and low phases are each exactly 2*CLK_DIV clocks; also check with CLK_DIV=1.
- Reset at go+200 during the reg byte: next clock scl=1, sda_o=1, busy=0, done never pulses.
  - A new go afterwards runs a clean full transaction.
- go pulsed again while busy and in the done cycle: both are ignored and inputs are not re-latched.
  - A go held high yields a second START one IDLE clock after done.
